// File: rtl/pmem_loader_if.sv
// pmem_loader_if: byte-stream input and program-memory write port of the loader
interface pmem_loader_if #(parameter int ADDR_WIDTH = 12);
   logic                  in_valid;
   logic [7:0]            in_data;
   logic                  in_ready;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [31:0]           wr_data;
   logic [3:0]            byte_w_en;
   logic                  cpu_hold;
   logic                  done;
   logic                  error;
   modport master (
      input  in_valid, in_data,
      output in_ready, wr_addr, wr_data, byte_w_en, cpu_hold, done, error
   );
   modport slave (
      output in_valid, in_data,
      input  in_ready, wr_addr, wr_data, byte_w_en, cpu_hold, done, error
   );
endinterface

// File: rtl/pmem_loader.sv
// pmem_loader: framed byte-stream loader that fills program memory and releases the CPU on a good checksum
module pmem_loader #(
   parameter int          ADDR_WIDTH     = 12,
   parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
   parameter int          TIMEOUT_CYCLES = 1000000
) (
   input  logic           sysclk,
   input  logic           rst,
   pmem_loader_if.master  bus
);
   localparam int             TW    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0]  TMAX  = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [16:0]    MAX_N = 17'(2 ** ADDR_WIDTH);
   typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, WRITE, CSUM, DONE, ERR} state_t;
   state_t                state, state_n;
   logic [15:0]           n, n_n;
   logic [1:0]            idx, idx_n;
   logic [7:0]            csum, csum_n;
   logic [TW-1:0]         tcnt, tcnt_n;
   logic [ADDR_WIDTH-1:0] addr_n;
   logic [31:0]           data_n;
   logic                  hold_n, done_n, err_n;
   logic                  acc, last;
   assign acc  = bus.in_valid & bus.in_ready;
   assign last = 17'(bus.wr_addr) == 17'(n) - 17'd1;
   always_comb begin
      state_n = state;
      n_n     = n;
      idx_n   = idx;
      csum_n  = csum;
      tcnt_n  = tcnt;
      addr_n  = bus.wr_addr;
      data_n  = bus.wr_data;
      hold_n  = bus.cpu_hold;
      done_n  = bus.done;
      err_n   = bus.error;
      case (state)
         IDLE, DONE, ERR: begin
            tcnt_n = '0;
            if (acc && bus.in_data == SYNC_BYTE) begin
               state_n = LEN0;
               hold_n  = 1'b1;
               done_n  = 1'b0;
               err_n   = 1'b0;
               addr_n  = '0;
               csum_n  = '0;
            end
         end
         LEN0: if (acc) begin
            n_n[7:0] = bus.in_data;
            state_n  = LEN1;
         end
         LEN1: if (acc) begin
            n_n[15:8] = bus.in_data;
            idx_n     = '0;
            err_n     = {1'b0, n_n} > MAX_N;
            state_n   = err_n ? ERR : (n_n == 16'd0) ? CSUM : DATA;
         end
         DATA: if (acc) begin
            data_n[8*idx +: 8] = bus.in_data;
            csum_n             = csum ^ bus.in_data;
            idx_n              = idx + 2'd1;
            state_n            = (idx == 2'd3) ? WRITE : DATA;
         end
         WRITE: begin
            addr_n  = last ? bus.wr_addr : bus.wr_addr + ADDR_WIDTH'(1);
            state_n = last ? CSUM : DATA;
         end
         CSUM: if (acc) begin
            done_n  = bus.in_data == csum;
            err_n   = !done_n;
            hold_n  = !done_n;
            state_n = done_n ? DONE : ERR;
         end
         default: state_n = IDLE;
      endcase
      // WRITE holds the idle counter; it never waits on the stream
      if (state inside {LEN0, LEN1, DATA, CSUM}) begin
         tcnt_n = acc ? '0 : tcnt + TW'(1);
         if (!acc && tcnt == TMAX) begin
            state_n = ERR;
            err_n   = 1'b1;
            tcnt_n  = '0;
         end
      end
   end
   always_ff @(posedge sysclk or negedge rst) begin
      if (!rst) begin
         state         <= IDLE;
         n             <= '0;
         idx           <= '0;
         csum          <= '0;
         tcnt          <= '0;
         bus.in_ready  <= 1'b0;
         bus.wr_addr   <= '0;
         bus.wr_data   <= '0;
         bus.byte_w_en <= 4'h0;
         bus.cpu_hold  <= 1'b1;
         bus.done      <= 1'b0;
         bus.error     <= 1'b0;
      end else begin
         state         <= state_n;
         n             <= n_n;
         idx           <= idx_n;
         csum          <= csum_n;
         tcnt          <= tcnt_n;
         bus.in_ready  <= state_n != WRITE;
         bus.wr_addr   <= addr_n;
         bus.wr_data   <= data_n;
         bus.byte_w_en <= (state_n == WRITE) ? 4'hF : 4'h0;
         bus.cpu_hold  <= hold_n;
         bus.done      <= done_n;
         bus.error     <= err_n;
      end
   end
endmodule

// File: tb/tb_pmem_loader.sv
// tb_pmem_loader: randomized frame stimulus against a word-list reference model of the loader
module tb_pmem_loader;
   localparam int AW = 12;
   typedef struct {logic [AW-1:0] addr; logic [31:0] data;} wr_t;
   logic sysclk = 1'b0;
   logic rst = 1'b1;
   int n_checks = 0;
   int n_pass = 0;
   int rdy_viol = 0;
   wr_t got[$];
   wr_t mon_w;
   logic [31:0] wq[$];
   always #5 sysclk = ~sysclk;
   pmem_loader_if #(.ADDR_WIDTH(AW)) bus();
   pmem_loader #(.ADDR_WIDTH(AW), .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(16)) dut (
      .sysclk(sysclk),
      .rst(rst),
      .bus(bus.master)
   );
   // every cycle with write enables asserted is one memory commit
   always @(negedge sysclk) begin
      if (bus.byte_w_en !== 4'h0) begin
         mon_w.addr = bus.wr_addr;
         mon_w.data = bus.wr_data;
         got.push_back(mon_w);
         if (bus.in_ready !== 1'b0 || bus.byte_w_en !== 4'hF) rdy_viol++;
      end
   end
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, want completion");
      $fatal(1);
   end
   task automatic send(input logic [7:0] b, input int gap);
      int t = 0;
      repeat (gap) begin
         @(negedge sysclk);
         bus.in_valid = 1'b0;
      end
      @(negedge sysclk);
      bus.in_valid = 1'b1;
      bus.in_data  = b;
      while (bus.in_ready !== 1'b1 && t < 20) begin
         @(negedge sysclk);
         t++;
      end
      if (t >= 20) begin
         n_checks++;
         $display("FAIL in_ready_wait: in_ready=%b after 20 cycles, want 1", bus.in_ready);
      end
      @(posedge sysclk);
   endtask
   task automatic idle();
      @(negedge sysclk);
      bus.in_valid = 1'b0;
   endtask
   task automatic send_frame(input logic [7:0] corrupt, input int gap);
      logic [7:0] cs = 8'h00;
      logic [15:0] nw = 16'(wq.size());
      logic [31:0] w;
      send(8'hA5, $urandom_range(0, gap));
      send(nw[7:0], $urandom_range(0, gap));
      send(nw[15:8], $urandom_range(0, gap));
      foreach (wq[i]) begin
         w = wq[i];
         for (int k = 0; k < 4; k++) begin
            cs ^= w[8*k +: 8];
            send(w[8*k +: 8], $urandom_range(0, gap));
         end
      end
      send(cs ^ corrupt, $urandom_range(0, gap));
      idle();
   endtask
   task automatic test_load(input logic [7:0] corrupt, input int gap);
      logic ok = corrupt == 8'h00;
      got.delete();
      rdy_viol = 0;
      send_frame(corrupt, gap);
      n_checks++; if (got.size() !== wq.size()) $display("FAIL write_count: got %0d want %0d", got.size(), wq.size()); else n_pass++;
      for (int i = 0; i < wq.size() && i < got.size(); i++) begin
         n_checks++; if (got[i].addr !== AW'(i)) $display("FAIL wr_addr[%0d]: got %0h want %0h", i, got[i].addr, i); else n_pass++;
         n_checks++; if (got[i].data !== wq[i]) $display("FAIL wr_data[%0d]: got %08h want %08h", i, got[i].data, wq[i]); else n_pass++;
      end
      n_checks++; if (rdy_viol !== 0) $display("FAIL write_cycle_ready: got %0d bad write cycles want 0", rdy_viol); else n_pass++;
      n_checks++; if (bus.done !== ok) $display("FAIL load_done: got %b want %b", bus.done, ok); else n_pass++;
      n_checks++; if (bus.error !== !ok) $display("FAIL load_error: got %b want %b", bus.error, !ok); else n_pass++;
      n_checks++; if (bus.cpu_hold !== !ok) $display("FAIL load_cpu_hold: got %b want %b", bus.cpu_hold, !ok); else n_pass++;
   endtask
   task automatic test_reset();
      bus.in_valid = 1'b0;
      bus.in_data  = 8'h00;
      rst = 1'b0;
      repeat (3) @(negedge sysclk);
      n_checks++; if (bus.cpu_hold !== 1'b1) $display("FAIL rst_cpu_hold: got %b want 1", bus.cpu_hold); else n_pass++;
      n_checks++; if (bus.in_ready !== 1'b0) $display("FAIL rst_in_ready: got %b want 0", bus.in_ready); else n_pass++;
      n_checks++; if (bus.byte_w_en !== 4'h0) $display("FAIL rst_byte_w_en: got %h want 0", bus.byte_w_en); else n_pass++;
      n_checks++; if (bus.wr_addr !== '0) $display("FAIL rst_wr_addr: got %h want 0", bus.wr_addr); else n_pass++;
      n_checks++; if (bus.wr_data !== '0) $display("FAIL rst_wr_data: got %h want 0", bus.wr_data); else n_pass++;
      rst = 1'b1;
      @(negedge sysclk);
      n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL post_rst_in_ready: got %b want 1", bus.in_ready); else n_pass++;
      n_checks++; if (bus.done !== 1'b0) $display("FAIL post_rst_done: got %b want 0", bus.done); else n_pass++;
      n_checks++; if (bus.error !== 1'b0) $display("FAIL post_rst_error: got %b want 0", bus.error); else n_pass++;
   endtask
   task automatic test_good_frame();
      wq = '{32'h12345678, 32'hDEADBEEF};
      test_load(8'h00, 0);
   endtask
   task automatic test_bad_csum();
      wq = '{32'h12345678, 32'hDEADBEEF};
      test_load(8'h01, 0);
      send(8'hA5, 0);
      idle();
      n_checks++; if (bus.error !== 1'b0) $display("FAIL resync_error: got %b want 0", bus.error); else n_pass++;
      n_checks++; if (bus.cpu_hold !== 1'b1) $display("FAIL resync_cpu_hold: got %b want 1", bus.cpu_hold); else n_pass++;
      send(8'h00, 0);
      send(8'h00, 0);
      send(8'h00, 0);
      idle();
   endtask
   task automatic test_zero();
      wq.delete();
      test_load(8'h00, 1);
   endtask
   task automatic test_oversize();
      got.delete();
      send(8'hA5, 0);
      send(8'h01, 0);
      send(8'h10, 0);
      idle();
      n_checks++; if (bus.error !== 1'b1) $display("FAIL oversize_error: got %b want 1", bus.error); else n_pass++;
      n_checks++; if (bus.done !== 1'b0) $display("FAIL oversize_done: got %b want 0", bus.done); else n_pass++;
      n_checks++; if (bus.cpu_hold !== 1'b1) $display("FAIL oversize_cpu_hold: got %b want 1", bus.cpu_hold); else n_pass++;
      repeat (3) @(negedge sysclk);
      n_checks++; if (got.size() !== 0) $display("FAIL oversize_writes: got %0d want 0", got.size()); else n_pass++;
   endtask
   task automatic test_max_len();
      send(8'hA5, 0);
      send(8'h00, 0);
      send(8'h10, 0);
      idle();
      n_checks++; if (bus.error !== 1'b0) $display("FAIL max_len_error: got %b want 0", bus.error); else n_pass++;
      rst = 1'b0;
      @(negedge sysclk);
      rst = 1'b1;
      @(negedge sysclk);
   endtask
   task automatic test_timeout();
      got.delete();
      send(8'hA5, 0);
      send(8'h02, 0);
      send(8'h00, 0);
      send(8'h11, 0);
      send(8'h22, 0);
      idle();
      repeat (15) @(negedge sysclk);
      n_checks++; if (bus.error !== 1'b0) $display("FAIL timeout_early: got %b want 0", bus.error); else n_pass++;
      @(negedge sysclk);
      n_checks++; if (bus.error !== 1'b1) $display("FAIL timeout_error: got %b want 1", bus.error); else n_pass++;
      n_checks++; if (bus.cpu_hold !== 1'b1) $display("FAIL timeout_cpu_hold: got %b want 1", bus.cpu_hold); else n_pass++;
      n_checks++; if (got.size() !== 0) $display("FAIL timeout_writes: got %0d want 0", got.size()); else n_pass++;
      wq = '{$urandom, $urandom, $urandom};
      test_load(8'h00, 2);
   endtask
   task automatic test_sync_as_data();
      wq = '{32'hA5A5A5A5, 32'h000000A5};
      test_load(8'h00, 0);
   endtask
   task automatic test_random();
      logic [7:0] corrupt;
      repeat (5) begin
         wq.delete();
         repeat ($urandom_range(1, 5)) wq.push_back($urandom);
         corrupt = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
         test_load(corrupt, 3);
      end
   endtask
   task automatic test_reset_mid_write();
      got.delete();
      send(8'hA5, 0);
      send(8'h01, 0);
      send(8'h00, 0);
      send(8'h01, 0);
      send(8'h02, 0);
      send(8'h03, 0);
      send(8'h04, 0);
      #1;
      n_checks++; if (bus.byte_w_en !== 4'hF) $display("FAIL write_en_active: got %h want f", bus.byte_w_en); else n_pass++;
      n_checks++; if (bus.wr_data !== 32'h04030201) $display("FAIL write_word: got %08h want 04030201", bus.wr_data); else n_pass++;
      bus.in_valid = 1'b0;
      rst = 1'b0;
      #1;
      n_checks++; if (bus.byte_w_en !== 4'h0) $display("FAIL async_byte_w_en: got %h want 0", bus.byte_w_en); else n_pass++;
      n_checks++; if (bus.in_ready !== 1'b0) $display("FAIL async_in_ready: got %b want 0", bus.in_ready); else n_pass++;
      n_checks++; if (bus.cpu_hold !== 1'b1) $display("FAIL async_cpu_hold: got %b want 1", bus.cpu_hold); else n_pass++;
      n_checks++; if (bus.wr_data !== '0) $display("FAIL async_wr_data: got %h want 0", bus.wr_data); else n_pass++;
      @(negedge sysclk);
      rst = 1'b1;
      @(negedge sysclk);
      n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL idle_in_ready: got %b want 1", bus.in_ready); else n_pass++;
      n_checks++; if (bus.done !== 1'b0) $display("FAIL idle_done: got %b want 0", bus.done); else n_pass++;
      n_checks++; if (got.size() !== 0) $display("FAIL aborted_writes: got %0d want 0", got.size()); else n_pass++;
      wq = '{$urandom, $urandom};
      test_load(8'h00, 1);
   endtask
   initial begin
      bus.in_valid = 1'b0;
      bus.in_data  = 8'h00;
      #2;
      test_reset();
      test_good_frame();
      test_bad_csum();
      test_zero();
      test_oversize();
      test_max_len();
      test_timeout();
      test_sync_as_data();
      test_random();
      test_reset_mid_write();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
